// File: rtl/stopwatch_lap_ctrl_pkg.sv
// Shared widths, FSM encoding and lap word layout for the stopwatch lap controller.
package stopwatch_lap_ctrl_pkg;

    localparam int MIN_W = 6;
    localparam int SEC_W = 6;
    localparam int MS_W  = 7;
    localparam int LAP_W = MIN_W + SEC_W + MS_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSE  = 2'd2,
        ST_RECALL = 2'd3
    } state_e;

    typedef struct packed {
        logic [MIN_W-1:0] min;
        logic [SEC_W-1:0] sec;
        logic [MS_W-1:0]  ms_10;
    } lap_t;

    function automatic lap_t pack_lap(input logic [MIN_W-1:0] m,
                                      input logic [SEC_W-1:0] s,
                                      input logic [MS_W-1:0]  ms);
        lap_t l;
        l.min   = m;
        l.sec   = s;
        l.ms_10 = ms;
        return l;
    endfunction

endpackage

// File: rtl/stopwatch_lap_ctrl_if.sv
// Bus between the lap controller and the counter/display datapath.
interface stopwatch_lap_ctrl_if;
    import stopwatch_lap_ctrl_pkg::*;

    // No valid/ready here: live time is a level sampled every clock, cnt_en is a level
    // and cnt_clr is a single-cycle strobe the counter must act on when it is seen high.
    logic [MIN_W-1:0] min_i;
    logic [SEC_W-1:0] sec_i;
    logic [MS_W-1:0]  ms_10_i;
    logic             cnt_en;
    logic             cnt_clr;
    logic [MIN_W-1:0] disp_min;
    logic [SEC_W-1:0] disp_sec;
    logic [MS_W-1:0]  disp_ms_10;

    modport master (
        input  min_i, sec_i, ms_10_i,
        output cnt_en, cnt_clr, disp_min, disp_sec, disp_ms_10
    );

    modport slave (
        output min_i, sec_i, ms_10_i,
        input  cnt_en, cnt_clr, disp_min, disp_sec, disp_ms_10
    );

endinterface

// File: rtl/stopwatch_lap_ctrl_key_pulse.sv
// Raw button to one-clock press pulse: 2-FF synchroniser, debounce counter, rising-edge detect.
module stopwatch_lap_ctrl_key_pulse #(
    parameter int DEB_CYCLES = 2_000_000,
    localparam int DC_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            stable_q, stable_d;
    logic            prev_q, prev_d;
    logic [DC_W-1:0] deb_q, deb_d;

    // The counter only advances while the synchronised level disagrees with the accepted
    // level; any agreement (a bounce back) restarts the qualification window.
    always_comb begin
        sync1_d  = btn;
        sync2_d  = sync1_q;
        prev_d   = stable_q;
        stable_d = stable_q;
        deb_d    = '0;
        if (sync2_q != stable_q) begin
            if (deb_q == DC_W'(DEB_CYCLES - 1)) begin
                stable_d = sync2_q;
            end else begin
                deb_d = deb_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
            deb_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            prev_q   <= prev_d;
            deb_q    <= deb_d;
        end
    end

    assign pulse = stable_q & ~prev_q;

endmodule

// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch control FSM: button handling, counter run/clear, lap capture and recall display.
module stopwatch_lap_ctrl
    import stopwatch_lap_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = 2_000_000,
    parameter int LAP_DEPTH  = 8,
    localparam int IDX_W = $clog2(LAP_DEPTH),
    localparam int CNT_W = IDX_W + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    btn_ss,
    input  logic                    btn_rec,
    input  logic                    btn_rcl,
    stopwatch_lap_ctrl_if.master    bus,
    output logic [CNT_W-1:0]        lap_cnt,
    output logic [IDX_W-1:0]        lap_idx,
    output logic                    lap_full,
    output logic [1:0]              state_o
);

    logic ss_p, rec_p, rcl_p;
    logic act_ss, act_rec, act_rcl;

    stopwatch_lap_ctrl_key_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_kp_ss (
        .clk(clk), .rst(rst), .btn(btn_ss), .pulse(ss_p)
    );
    stopwatch_lap_ctrl_key_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_kp_rec (
        .clk(clk), .rst(rst), .btn(btn_rec), .pulse(rec_p)
    );
    stopwatch_lap_ctrl_key_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_kp_rcl (
        .clk(clk), .rst(rst), .btn(btn_rcl), .pulse(rcl_p)
    );

    // Start/stop outranks record, which outranks recall; losers are simply dropped.
    assign act_ss  = ss_p;
    assign act_rec = rec_p & ~ss_p;
    assign act_rcl = rcl_p & ~ss_p & ~rec_p;

    state_e           state_q, state_d;
    state_e           ret_q, ret_d;
    logic [CNT_W-1:0] lap_cnt_q, lap_cnt_d;
    logic [IDX_W-1:0] lap_idx_q, lap_idx_d;
    logic             cnt_en_q, cnt_en_d;
    logic             cnt_clr_q, cnt_clr_d;
    lap_t             disp_q, disp_d;

    logic             wr_en;
    logic [IDX_W-1:0] wr_addr;
    lap_t             live_lap;
    lap_t             mem_q [LAP_DEPTH];
    logic             have_laps;
    logic             idx_last;

    assign live_lap  = pack_lap(bus.min_i, bus.sec_i, bus.ms_10_i);
    assign lap_full  = (lap_cnt_q == CNT_W'(LAP_DEPTH));
    assign have_laps = (lap_cnt_q != '0);
    assign idx_last  = (lap_idx_q == IDX_W'(lap_cnt_q - 1'b1));

    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        lap_cnt_d = lap_cnt_q;
        lap_idx_d = lap_idx_q;
        cnt_clr_d = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = lap_cnt_q[IDX_W-1:0];
        unique case (state_q)
            ST_IDLE: begin
                if (act_ss) begin
                    state_d = ST_RUN;
                end else if (act_rcl && have_laps) begin
                    state_d   = ST_RECALL;
                    lap_idx_d = '0;
                    ret_d     = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (act_ss) begin
                    state_d = ST_PAUSE;
                end else if (act_rec && !lap_full) begin
                    wr_en     = 1'b1;
                    lap_cnt_d = lap_cnt_q + 1'b1;
                end
            end
            ST_PAUSE: begin
                if (act_ss) begin
                    state_d = ST_RUN;
                end else if (act_rec) begin
                    state_d   = ST_IDLE;
                    cnt_clr_d = 1'b1;
                    lap_cnt_d = '0;
                    lap_idx_d = '0;
                end else if (act_rcl && have_laps) begin
                    state_d   = ST_RECALL;
                    lap_idx_d = '0;
                    ret_d     = ST_PAUSE;
                end
            end
            ST_RECALL: begin
                if (act_ss || act_rec) begin
                    state_d = ret_q;
                end else if (act_rcl && have_laps) begin
                    lap_idx_d = idx_last ? '0 : lap_idx_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        cnt_en_d = (state_d == ST_RUN);
    end

    // Display lags the selection by one clock; recall reads the lap register array directly.
    always_comb begin
        disp_d = live_lap;
        if (state_q == ST_RECALL) begin
            disp_d = mem_q[lap_idx_q];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            ret_q     <= ST_IDLE;
            lap_cnt_q <= '0;
            lap_idx_q <= '0;
            cnt_en_q  <= 1'b0;
            cnt_clr_q <= 1'b0;
            disp_q    <= '0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            lap_cnt_q <= lap_cnt_d;
            lap_idx_q <= lap_idx_d;
            cnt_en_q  <= cnt_en_d;
            cnt_clr_q <= cnt_clr_d;
            disp_q    <= disp_d;
        end
    end

    // Lap contents are meaningless after reset because lap_cnt gates every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= live_lap;
        end
    end

    assign bus.cnt_en     = cnt_en_q;
    assign bus.cnt_clr    = cnt_clr_q;
    assign bus.disp_min   = disp_q.min;
    assign bus.disp_sec   = disp_q.sec;
    assign bus.disp_ms_10 = disp_q.ms_10;
    assign lap_cnt        = lap_cnt_q;
    assign lap_idx        = lap_idx_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Directed bench for stopwatch_lap_ctrl with short debounce and a 4-entry lap buffer.
module tb_stopwatch_lap_ctrl;

    logic       clk;
    logic       rst;
    logic       btn_ss, btn_rec, btn_rcl;
    logic [2:0] lap_cnt;
    logic [1:0] lap_idx;
    logic       lap_full;
    logic [1:0] state_o;
    int         vec_cnt;
    int         miss_cnt;
    int         clr_seen;

    stopwatch_lap_ctrl_if bus ();

    stopwatch_lap_ctrl #(.DEB_CYCLES(4), .LAP_DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_ss   (btn_ss),
        .btn_rec  (btn_rec),
        .btn_rcl  (btn_rcl),
        .bus      (bus),
        .lap_cnt  (lap_cnt),
        .lap_idx  (lap_idx),
        .lap_full (lap_full),
        .state_o  (state_o)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (bus.cnt_clr === 1'b1) clr_seen++;
    end

    function automatic logic [18:0] lap(input int m, input int s, input int ms);
        logic [5:0] mm;
        logic [5:0] ss;
        logic [6:0] ms7;
        mm  = m[5:0];
        ss  = s[5:0];
        ms7 = ms[6:0];
        return {mm, ss, ms7};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vec_cnt++;
        assert (obs === expv) else begin
            miss_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic set_live(input int m, input int s, input int ms);
        @(negedge clk);
        bus.min_i   = 6'(m);
        bus.sec_i   = 6'(s);
        bus.ms_10_i = 7'(ms);
    endtask

    // driver: hold buttons 10 clocks, release, wait for the release to debounce
    task automatic press(input logic s, input logic r, input logic c);
        @(negedge clk);
        btn_ss  = s;
        btn_rec = r;
        btn_rcl = c;
        repeat (10) @(negedge clk);
        btn_ss  = 1'b0;
        btn_rec = 1'b0;
        btn_rcl = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    function automatic logic [18:0] disp_now();
        return {bus.disp_min, bus.disp_sec, bus.disp_ms_10};
    endfunction

    initial begin
        vec_cnt     = 0;
        miss_cnt    = 0;
        clr_seen    = 0;
        rst         = 1'b0;
        btn_ss      = 1'b0;
        btn_rec     = 1'b0;
        btn_rcl     = 1'b0;
        bus.min_i   = 6'd1;
        bus.sec_i   = 6'd2;
        bus.ms_10_i = 7'd3;

        // 1. reset values, then start with exact latency
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_cnt_en", 32'(bus.cnt_en), 32'd0);
        check("rst_cnt_clr", 32'(bus.cnt_clr), 32'd0);
        check("rst_disp", 32'(disp_now()), 32'd0);
        check("rst_lap_cnt", 32'(lap_cnt), 32'd0);
        check("rst_lap_idx", 32'(lap_idx), 32'd0);
        check("rst_lap_full", 32'(lap_full), 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        btn_ss = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("start_before_lat", 32'(bus.cnt_en), 32'd0);
        @(posedge clk);
        #1;
        check("start_cnt_en", 32'(bus.cnt_en), 32'd1);
        check("start_state", 32'(state_o), 32'd1);
        repeat (3) @(negedge clk);
        btn_ss = 1'b0;
        repeat (10) @(negedge clk);
        check("run_disp_live", 32'(disp_now()), 32'(lap(1, 2, 3)));

        // 2. bounce shorter than the debounce window
        for (int i = 0; i < 5; i++) begin
            btn_ss = 1'b1;
            repeat (2) @(negedge clk);
            btn_ss = 1'b0;
            repeat (2) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        check("bounce_state", 32'(state_o), 32'd1);
        check("bounce_cnt_en", 32'(bus.cnt_en), 32'd1);

        // 3. lap capture up to full, fifth record ignored
        press(1'b0, 1'b1, 1'b0);
        check("rec1_cnt", 32'(lap_cnt), 32'd1);
        set_live(1, 3, 10);
        press(1'b0, 1'b1, 1'b0);
        check("rec2_cnt", 32'(lap_cnt), 32'd2);
        set_live(2, 59, 99);
        press(1'b0, 1'b1, 1'b0);
        check("rec3_full", 32'(lap_full), 32'd0);
        set_live(5, 0, 50);
        press(1'b0, 1'b1, 1'b0);
        check("rec4_cnt", 32'(lap_cnt), 32'd4);
        check("rec4_full", 32'(lap_full), 32'd1);
        set_live(7, 7, 7);
        press(1'b0, 1'b1, 1'b0);
        check("rec5_cnt", 32'(lap_cnt), 32'd4);
        press(1'b0, 1'b0, 1'b1);
        check("rcl_in_run", 32'(state_o), 32'd1);

        // 4. pause, recall walk with display latency
        press(1'b1, 1'b0, 1'b0);
        check("pause_state", 32'(state_o), 32'd2);
        check("pause_cnt_en", 32'(bus.cnt_en), 32'd0);
        check("pause_disp_live", 32'(disp_now()), 32'(lap(7, 7, 7)));
        @(negedge clk);
        btn_rcl = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        check("recall_state", 32'(state_o), 32'd3);
        check("recall_disp_lag", 32'(disp_now()), 32'(lap(7, 7, 7)));
        @(posedge clk);
        #1;
        check("recall_disp0", 32'(disp_now()), 32'(lap(1, 2, 3)));
        repeat (2) @(negedge clk);
        btn_rcl = 1'b0;
        repeat (10) @(negedge clk);
        check("recall_idx0", 32'(lap_idx), 32'd0);
        press(1'b0, 1'b0, 1'b1);
        check("recall_idx1", 32'(lap_idx), 32'd1);
        check("recall_disp1", 32'(disp_now()), 32'(lap(1, 3, 10)));
        press(1'b0, 1'b0, 1'b1);
        check("recall_idx2", 32'(lap_idx), 32'd2);
        check("recall_disp2", 32'(disp_now()), 32'(lap(2, 59, 99)));
        press(1'b0, 1'b0, 1'b1);
        check("recall_idx3", 32'(lap_idx), 32'd3);
        check("recall_disp3", 32'(disp_now()), 32'(lap(5, 0, 50)));
        press(1'b0, 1'b0, 1'b1);
        check("recall_wrap", 32'(lap_idx), 32'd0);
        check("recall_cnt_en", 32'(bus.cnt_en), 32'd0);
        press(1'b1, 1'b0, 1'b0);
        check("recall_ret", 32'(state_o), 32'd2);

        // 5. clear from pause, recall with no laps ignored
        clr_seen = 0;
        press(1'b0, 1'b1, 1'b0);
        check("clr_pulses", 32'(clr_seen), 32'd1);
        check("clr_state", 32'(state_o), 32'd0);
        check("clr_lap_cnt", 32'(lap_cnt), 32'd0);
        check("clr_lap_full", 32'(lap_full), 32'd0);
        press(1'b0, 1'b0, 1'b1);
        check("idle_rcl_empty", 32'(state_o), 32'd0);
        check("idle_disp_live", 32'(disp_now()), 32'(lap(7, 7, 7)));

        // 6. simultaneous ss+rec in RUN, then async reset mid-run
        press(1'b1, 1'b0, 1'b0);
        set_live(3, 4, 5);
        press(1'b0, 1'b1, 1'b0);
        check("run2_lap_cnt", 32'(lap_cnt), 32'd1);
        press(1'b1, 1'b1, 1'b0);
        check("prio_state", 32'(state_o), 32'd2);
        check("prio_lap_cnt", 32'(lap_cnt), 32'd1);
        press(1'b1, 1'b0, 1'b0);
        check("rerun_cnt_en", 32'(bus.cnt_en), 32'd1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_cnt_en", 32'(bus.cnt_en), 32'd0);
        check("async_state", 32'(state_o), 32'd0);
        check("async_lap_cnt", 32'(lap_cnt), 32'd0);
        check("async_disp", 32'(disp_now()), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
